// File: rtl/jk_ff_pkg.sv
// jk_ff_pkg: JK command encoding, next-state helper and width limit
package jk_ff_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;

    localparam int JK_MAX_WIDTH = 64;

    function automatic logic jk_next(input jk_cmd_e cmd, input logic q_cur);
        return cmd == JK_HOLD  ? q_cur :
               cmd == JK_RESET ? 1'b0  :
               cmd == JK_SET   ? 1'b1  : ~q_cur;
    endfunction

endpackage

// File: rtl/jk_ff_bit.sv
// jk_ff_bit: single JK flop with asynchronous active-low clear to rst_val
module jk_ff_bit
    import jk_ff_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic j,
    input  logic k,
    input  logic rst_val,
    output logic q
);

    always_ff @(posedge clk or negedge clr)
        if (!clr) q <= rst_val;
        else      q <= jk_next(jk_cmd_e'({j, k}), q);

endmodule

// File: rtl/jk_ff_sync.sv
// jk_ff_sync: bank of WIDTH independent JK flops sharing clk and async clear
// Define JK_FF_SYNC_QN_EN to add the complementary output qn.
module jk_ff_sync
    import jk_ff_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
`ifdef JK_FF_SYNC_QN_EN
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
`else
    output logic [WIDTH-1:0] q
`endif
);

    if (WIDTH < 1 || WIDTH > JK_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "jk_ff_sync: WIDTH %0d outside 1..%0d", WIDTH, JK_MAX_WIDTH);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_bit u_bit (
            .clk    (clk),
            .clr    (clr),
            .j      (j[i]),
            .k      (k[i]),
            .rst_val(RESET_VAL[i]),
            .q      (q[i])
        );
    end

`ifdef JK_FF_SYNC_QN_EN
    assign qn = ~q;
`endif

endmodule

// File: tb/tb_jk_ff_sync.sv
// tb_jk_ff_sync: table, directed and random checks of jk_ff_sync against a
// characteristic-equation model (q' = j&~q | ~k&q).
module tb_jk_ff_sync;

    localparam logic [3:0] RV = 4'b0101;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] j = '0;
    logic [3:0] k = '0;
    logic [3:0] q4;
    logic [0:0] q1;
    logic [3:0] m4;
    logic       m1;
    int         vectors = 0;
    int         miscompares = 0;
`ifdef JK_FF_SYNC_QN_EN
    logic [3:0] qn4;
    logic [0:0] qn1;
`endif

    always #5 clk = ~clk;

    jk_ff_sync #(.WIDTH(4), .RESET_VAL(RV)) u_dut (
        .clk(clk), .clr(clr), .j(j), .k(k),
`ifdef JK_FF_SYNC_QN_EN
        .qn(qn4),
`endif
        .q(q4)
    );

    jk_ff_sync u_one (
        .clk(clk), .clr(clr), .j(j[0]), .k(k[0]),
`ifdef JK_FF_SYNC_QN_EN
        .qn(qn1),
`endif
        .q(q1)
    );

    typedef struct {
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] q;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name);
        chk({name, ".q4"}, q4, m4);
        chk({name, ".q1"}, {3'b0, q1}, {3'b0, m1});
`ifdef JK_FF_SYNC_QN_EN
        chk({name, ".qn4"}, qn4, ~m4);
        chk({name, ".qn1"}, {3'b0, qn1}, {3'b0, ~m1});
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (clr) begin
            m4 = (j & ~m4) | (~k & m4);
            m1 = (j[0] & ~m1) | (~k[0] & m1);
        end else begin
            m4 = RV;
            m1 = 1'b0;
        end
        #1;
    endtask

    task automatic async_clr();
        @(negedge clk);
        #1 clr = 1'b0;
        m4 = RV;
        m1 = 1'b0;
        #1 chk_all("async_clr");
    endtask

    initial begin
        tbl[0]  = '{4'b0000, 4'b0000, 4'b0101};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b0101};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b0101};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b1111};
        tbl[4]  = '{4'b0000, 4'b1111, 4'b0000};
        tbl[5]  = '{4'b0000, 4'b1111, 4'b0000};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b1111};
        tbl[7]  = '{4'b1111, 4'b1111, 4'b0000};
        tbl[8]  = '{4'b1111, 4'b1111, 4'b1111};
        tbl[9]  = '{4'b1111, 4'b1111, 4'b0000};
        tbl[10] = '{4'b1111, 4'b1111, 4'b1111};
        tbl[11] = '{4'b0000, 4'b1100, 4'b0011};
        tbl[12] = '{4'b1010, 4'b0110, 4'b1001};

        #1 clr = 1'b0;
        m4 = RV;
        m1 = 1'b0;
        #1 chk_all("reset");
        j = '1;
        tick();
        chk_all("reset_hold");
        @(negedge clk) clr = 1'b1;
        j = '0;

        for (int i = 0; i < 13; i++) begin
            j = tbl[i].j;
            k = tbl[i].k;
            tick();
            chk("table", q4, tbl[i].q);
            chk("table.q1", {3'b0, q1}, {3'b0, m1});
        end

        // inputs wiggling between edges must not disturb q
        j = 4'b1111; k = 4'b0000;
        #3 j = 4'b0000; k = 4'b1111;
        #1 chk("stable", q4, 4'b1001);
        tick();
        chk_all("reset_cmd");
        j = 4'b1111; k = 4'b0000;
        tick();
        chk_all("set_cmd");
        async_clr();
        tick();
        chk_all("clr_held");
        @(negedge clk) clr = 1'b1;
        j = 4'b1111; k = 4'b1111;
        tick();
        chk("resume", q4, 4'b1010);
        j = 4'b1111; k = 4'b0000;
        @(posedge clk) clr = 1'b0;
        m4 = RV;
        m1 = 1'b0;
        #1 chk_all("clr_at_edge");
        @(negedge clk) clr = 1'b1;

        for (int n = 0; n < 300; n++) begin
            j = 4'($urandom);
            k = 4'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                async_clr();
                @(negedge clk) clr = 1'b1;
            end else begin
                tick();
                chk_all("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
